// File: rtl/serial_subtr.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB-first,
// one bit per clock, and returns S/Cout plus Zero/Lt compare flags.
module serial_subtr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Mod,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Zero,
  output logic             Lt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic             mod_q;
  logic [CW-1:0]    cnt;

  logic             sum_c;
  logic             carry_c;
  logic [WIDTH-1:0] res_c;

  // Full-adder cell and the result as it will stand after this edge's shift
  always_comb begin
    sum_c   = a_sr[0] ^ b_sr[0] ^ c;
    carry_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    res_c   = {sum_c, r_sr[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CW'(WIDTH - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c     <= 1'b0;
      mod_q <= 1'b0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Zero  <= 1'b0;
      Lt    <= 1'b0;
    end else begin
      Busy <= (state_nxt != ST_IDLE);
      Done <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (Start) begin
            a_sr  <= A;
            b_sr  <= B ^ {WIDTH{Mod}};
            c     <= Cin ^ Mod;
            mod_q <= Mod;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          c    <= carry_c;
          r_sr <= res_c;
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          // Final bit: publish the completed result and flags
          if (state_nxt == ST_DONE) begin
            S    <= res_c;
            Cout <= carry_c;
            Zero <= (res_c == '0);
            Lt   <= mod_q & ~carry_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtr.sv
// Directed self-checking bench for serial_subtr (WIDTH=8) with hand-computed results.
module tb_serial_subtr;

  localparam int unsigned WIDTH = 8;

  logic             Clk;
  logic             Rst_n;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Mod;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Zero;
  logic             Lt;

  int n_chk;
  int n_err;

  serial_subtr #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Mod   (Mod),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout),
    .Zero  (Zero),
    .Lt    (Lt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Wait for Done (bounded); returns edges since acceptance, 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic mod, input logic [7:0] exp_s,
                        input logic exp_cout, input logic exp_zero, input logic exp_lt);
    int lat;
    A = a; B = b; Cin = cin; Mod = mod; Start = 1'b1;
    tick();
    Start = 1'b0;
    // Scramble inputs after acceptance; the result must not depend on them
    A = ~a; B = ~b; Cin = ~cin; Mod = ~mod;
    chk({tag, "_busy"}, 32'(Busy), 32'(1));
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(WIDTH));
    chk({tag, "_s"}, 32'(S), 32'(exp_s));
    chk({tag, "_cout"}, 32'(Cout), 32'(exp_cout));
    chk({tag, "_zero"}, 32'(Zero), 32'(exp_zero));
    chk({tag, "_lt"}, 32'(Lt), 32'(exp_lt));
    tick();
    chk({tag, "_done_drop"}, 32'(Done), 32'(0));
    chk({tag, "_busy_drop"}, 32'(Busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int n_done;
    int last_done;
    int run;
    int max_run;
    int spacing_bad;
    n_chk = 0;
    n_err = 0;
    A = '0; B = '0; Cin = 1'b0; Mod = 1'b0;
    // Start during reset must be discarded
    Rst_n = 1'b0;
    Start = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(Busy), 32'(0));
    chk("rst_done", 32'(Done), 32'(0));
    chk("rst_s", 32'(S), 32'(0));
    chk("rst_cout", 32'(Cout), 32'(0));
    chk("rst_zero", 32'(Zero), 32'(0));
    chk("rst_lt", 32'(Lt), 32'(0));
    Rst_n = 1'b1;
    Start = 1'b0;
    tick();
    chk("rst_start_discard", 32'(Busy), 32'(0));

    run_op("sub_gt",  8'hB9, 8'h8F, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
    run_op("sub_lt",  8'hB9, 8'hE5, 1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b1);
    run_op("sub_lt2", 8'hCA, 8'hF3, 1'b0, 1'b1, 8'hD7, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq",  8'h9A, 8'h9A, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_bin", 8'hD5, 8'hD4, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("add_wrap", 8'hE6, 8'h1A, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);

    // Second Start at edge 3 of a busy operation is ignored
    A = 8'hB9; B = 8'h8F; Cin = 1'b0; Mod = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    A = 8'h00; B = 8'hFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(lat);
    chk("hs_lat", 32'(lat + 3), 32'(WIDTH));
    chk("hs_s", 32'(S), 32'(8'h2A));
    chk("hs_cout", 32'(Cout), 32'(1));
    tick();
    tick();
    chk("hs_no_queue", 32'(Busy), 32'(0));

    // Reset at edge 4 of an operation aborts it with outputs cleared
    A = 8'hB9; B = 8'hE5; Cin = 1'b0; Mod = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    Rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(Busy), 32'(0));
    chk("mid_rst_done", 32'(Done), 32'(0));
    chk("mid_rst_s", 32'(S), 32'(0));
    chk("mid_rst_cout", 32'(Cout), 32'(0));
    chk("mid_rst_zero", 32'(Zero), 32'(0));
    chk("mid_rst_lt", 32'(Lt), 32'(0));
    Rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 32'(0));
    run_op("post_rst", 8'h10, 8'h05, 1'b0, 1'b1, 8'h0B, 1'b1, 1'b0, 1'b0);

    // Start held high: accepted every WIDTH+2 edges, Done one cycle wide
    A = 8'h10; B = 8'h01; Cin = 1'b0; Mod = 1'b0; Start = 1'b1;
    n_done = 0;
    last_done = -1;
    run = 0;
    max_run = 0;
    spacing_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) begin
        run++;
        if (run > max_run) max_run = run;
        if (run == 1) begin
          n_done++;
          if (last_done >= 0 && (i - last_done) != int'(WIDTH + 2)) spacing_bad++;
          if (last_done < 0 && i != int'(WIDTH)) spacing_bad++;
          last_done = i;
          chk("b2b_s", 32'(S), 32'(8'h11));
        end
      end else begin
        run = 0;
      end
    end
    Start = 1'b0;
    chk("b2b_count", 32'(n_done), 32'(4));
    chk("b2b_spacing", 32'(spacing_bad), 32'(0));
    chk("b2b_done_width", 32'(max_run), 32'(1));
    tick();
    tick();
    chk("b2b_idle", 32'(Busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
